// File: rtl/mdu_sequencer.sv
// mdu_sequencer
//   Multi-cycle sequencer for the RV32M multiply/divide unit. Accepts one
//   M-extension operation on a valid/ready request port. Multiplies use
//   shift-add iterations and divides use restoring iterations, both on
//   operand magnitudes. RISC-V sign rules and the divide special cases
//   (divide by zero, signed overflow) are applied before the result is
//   offered on a valid/ready response port.
//
//   Optional build macro: MDU_FAST_MUL_EN
//     defined   - multiply ops form the full product in PREP and skip CALC
//     undefined - multiply ops iterate in CALC like divides
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   req_valid    request strobe
//   req_ready    sequencer is idle and can take a request
//   funct3       M-op select (MUL..REMU)
//   op_a, op_b   rs1 / rs2 values, captured at accept only
//   kill         abort the in-flight operation (PREP/CALC/FIX only)
//   resp_valid   result available
//   resp_ready   consumer takes the result
//   resp_result  result value
//   busy         operation accepted and response not yet consumed
module mdu_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy
);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_next;

  logic [2:0]        op;
  logic [XLEN-1:0]   a, b;
  logic [XLEN-1:0]   divisor;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_step;
  logic [CNT_W-1:0]  cnt;
  logic              neg_res, neg_rem;
  logic [XLEN-1:0]   res;

  logic            is_div, a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, last_iter;

  // MULH/MULHSU/DIV/REM treat rs1 as signed; MULH/DIV/REM treat rs2 as signed.
  // MUL is handled unsigned because only the low half is returned.
  assign is_div    = op[2];
  assign a_signed  = is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
  assign b_signed  = is_div ? ~op[0] : (op[1:0] == 2'b01);
  assign sign_a    = a_signed & a[XLEN-1];
  assign sign_b    = b_signed & b[XLEN-1];
  assign mag_a     = sign_a ? -a : a;
  assign mag_b     = sign_b ? -b : b;
  assign div_zero  = is_div && (b == '0);
  assign div_ovf   = is_div && !op[0] && (a == MIN_NEG) && (b == '1);
  assign last_iter = (cnt == CNT_W'(XLEN-1));

  // One iteration step. For multiply acc = {partial sum, remaining multiplier};
  // for divide acc = {partial remainder, dividend bits becoming quotient bits}.
  logic [XLEN:0] add_sum, sh_rem, diff;
  assign add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, divisor};
  assign sh_rem  = acc[2*XLEN-1:XLEN-1];
  assign diff    = sh_rem - {1'b0, divisor};

  always_comb begin
    acc_step = acc;
    if (is_div) begin
      if (!diff[XLEN]) acc_step = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else             acc_step = {sh_rem[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_step = {add_sum, acc[XLEN-1:1]};
    end else begin
      acc_step = {1'b0, acc[2*XLEN-1:1]};
    end
  end

  // Sign correction and half/part selection applied in FIX.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (is_div)                fix_val = op[1] ? rem_fix : quo_fix;
    else if (op[1:0] == 2'b00) fix_val = prod_fix[XLEN-1:0];
    else                       fix_val = prod_fix[2*XLEN-1:XLEN];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic. kill only matters while the operation is computing.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) state_next = PREP;
      PREP: begin
        if (kill)                     state_next = IDLE;
        else if (div_zero || div_ovf) state_next = DONE;
`ifdef MDU_FAST_MUL_EN
        else if (!is_div)             state_next = FIX;
`endif
        else                          state_next = CALC;
      end
      CALC: begin
        if (kill)           state_next = IDLE;
        else if (last_iter) state_next = FIX;
      end
      FIX:  state_next = kill ? IDLE : DONE;
      DONE: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == DONE);
    busy       = (state != IDLE);
  end

  assign resp_result = res;

  // Datapath registers. res is only written on the way into DONE, so it
  // stays stable while the response waits for resp_ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op      <= '0;
      a       <= '0;
      b       <= '0;
      divisor <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      res     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op <= funct3;
            a  <= op_a;
            b  <= op_b;
          end
        end
        PREP: begin
          neg_res <= sign_a ^ sign_b;
          neg_rem <= sign_a;
          cnt     <= '0;
          if (is_div) begin
            acc     <= {{XLEN{1'b0}}, mag_a};
            divisor <= mag_b;
            if (div_zero)     res <= op[1] ? a : '1;
            else if (div_ovf) res <= op[1] ? '0 : a;
          end else begin
`ifdef MDU_FAST_MUL_EN
            acc <= (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
`else
            acc     <= {{XLEN{1'b0}}, mag_b};
            divisor <= mag_a;
`endif
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: res <= fix_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer
//   Self-checking bench for mdu_sequencer (XLEN=32). Expected results are
//   pushed into a scoreboard queue when a request is accepted and popped
//   when the response handshake happens. Latency is counted in clock edges
//   after the accept edge (the accept edge itself is not counted).
module tb_mdu_sequencer;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            kill;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;
  logic            busy;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] expected_q[$];

  mdu_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .funct3(funct3),
    .op_a(op_a),
    .op_b(op_b),
    .kill(kill),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_result(resp_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference RV32M behaviour using wide native arithmetic.
  function automatic logic [31:0] mdu_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sub;
    logic [63:0] p;
    logic signed [31:0] q;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    sub = {32'd0, b};
    mdu_model = '0;
    case (f)
      3'b000: begin p = {32'd0, a} * {32'd0, b}; mdu_model = p[31:0];  end
      3'b001: begin p = sa * sb;                 mdu_model = p[63:32]; end
      3'b010: begin p = sa * sub;                mdu_model = p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; mdu_model = p[63:32]; end
      default: begin
        if (b == 32'd0) mdu_model = f[1] ? a : 32'hFFFF_FFFF;
        else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) mdu_model = f[1] ? 32'd0 : a;
        else begin
          case (f)
            3'b100:  begin q = $signed(a) / $signed(b); mdu_model = q; end
            3'b101:  mdu_model = a / b;
            3'b110:  begin q = $signed(a) % $signed(b); mdu_model = q; end
            default: mdu_model = a % b;
          endcase
        end
      end
    endcase
  endfunction

  // Divide special cases reach DONE on the edge right after the accept edge
  // (the 2nd edge counting the accept edge); iterated ops take XLEN+2.
  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MDU_FAST_MUL_EN
    if (!f[2]) return 2;
`endif
    return XLEN + 2;
  endfunction

  task automatic popResponse();
    checkOutput("resp_valid at handshake", resp_valid, 1);
    if (expected_q.size() == 0) checkOutput("unexpected response", 1, 0);
    else checkOutput("resp_result", resp_result, expected_q.pop_front());
  endtask

  // Issue one op, check busy/latency, optionally stall the response for
  // 'hold' cycles (with a stray request and kill), then consume it.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_res, input int hold);
    int lat;
    bit busy_ok;
    resp_ready = (hold == 0);
    lat = 0;
    while (!req_ready && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    checkOutput("req_ready before accept", req_ready, 1);
    funct3 = f; op_a = a; op_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    expected_q.push_back(exp_res);
    req_valid = 1'b0;
    funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
    lat = 0;
    busy_ok = 1'b1;
    while (!resp_valid && lat < 200) begin
      if (!busy || req_ready) busy_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    checkOutput("busy while in flight", busy_ok, 1);
    checkOutput("latency", lat, exp_latency(f, a, b));
    if (hold > 0) begin
      req_valid = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd5; kill = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        checkOutput("hold resp_valid", resp_valid, 1);
        checkOutput("hold resp_result", resp_result, exp_res);
        checkOutput("hold req_ready", req_ready, 0);
      end
      req_valid = 1'b0; kill = 1'b0;
      resp_ready = 1'b1;
    end
    popResponse();
    @(posedge clk); #1;
    checkOutput("idle after handshake", req_ready, 1);
    checkOutput("resp_valid drop", resp_valid, 0);
  endtask

  // Start a MUL, then abort it with rst or kill while CALC holds cnt=10.
  task automatic applyAbort(input bit use_rst);
    bit pulse;
    resp_ready = 1'b1;
    funct3 = 3'b000; op_a = 32'h1234; op_b = 32'h5678; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("abort op accepted", busy, 1);
    repeat (11) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b0;
    else         kill = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; kill = 1'b0;
    checkOutput(use_rst ? "rst abort req_ready" : "kill abort req_ready", req_ready, 1);
    checkOutput(use_rst ? "rst abort busy" : "kill abort busy", busy, 0);
    checkOutput(use_rst ? "rst abort resp_valid" : "kill abort resp_valid", resp_valid, 0);
    if (use_rst) checkOutput("rst abort resp_result", resp_result, 0);
    pulse = 1'b0;
    repeat (XLEN + 8) begin
      if (resp_valid) pulse = 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("no response after abort", pulse, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    rst = 1'b0; req_valid = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    kill = 1'b0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset req_ready", req_ready, 1);
    checkOutput("reset resp_valid", resp_valid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset resp_result", resp_result, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed multiply");
    applyStimulus(3'b000, 32'd10, 32'd3, 32'd30, 0);
    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    applyStimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    applyStimulus(3'b010, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF, 0);

    $display("[TB] directed divide");
    applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    applyStimulus(3'b101, 32'd12, 32'd3, 32'd4, 0);
    applyStimulus(3'b111, 32'd10, 32'd3, 32'd1, 0);

    $display("[TB] divide special cases");
    applyStimulus(3'b101, 32'd12, 32'd0, 32'hFFFF_FFFF, 0);
    applyStimulus(3'b111, 32'd12, 32'd0, 32'd12, 0);
    applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    applyStimulus(3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0);

    $display("[TB] response back-pressure");
    applyStimulus(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 5);
    applyStimulus(3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 0);

    $display("[TB] abort by reset and kill");
    applyAbort(1'b1);
    applyAbort(1'b0);
    applyStimulus(3'b101, 32'd1000, 32'd7, 32'd142, 0);

    $display("[TB] random operations");
    for (int i = 0; i < 16; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      applyStimulus(rf, ra, rb, mdu_model(rf, ra, rb), 0);
    end

    checkOutput("scoreboard drained", expected_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
